wdt32_seq: RTL
==============

# wdt32_seq

Two-stage watchdog sequencer that drives the control inputs of the WDT32 timer macro (load value, enable, overflow clear) and interprets its overflow flag. It sits between the APB_sys_0 software-facing watchdog registers and the macro. It adds keyed kicks, a warning stage (interrupt plus grace period) and a bite stage (timed system reset request). Software never touches WDEN, WDLOAD or WDOVCLR directly.

## Interface
- RST_CYCLES, 16: width of the rst_req pulse in PCLK cycles (≥1).
- KEY1, 8'h5A: first kick key.
- KEY2, 8'hA5: second kick key.

Ports:
- PCLK  in  1  sole clock, rising edge.
- PRESET  in  1  reset; asynchronous, active-high.
- cfg_load  in  32  first-stage timeout count.
- cfg_grace  in  32  second-stage (grace) count.
- cfg_en  in  1  enable request; level, armed on rising edge.
- cfg_lock  in  1  sampled at arm; when set, cfg_en low is ignored.
- kick_wr  in  1  one-cycle kick write strobe.
- kick_key  in  8  kick data, valid with kick_wr.
- irq_clr  in  1  one-cycle strobe, clears irq.
- WDOV  in  1  overflow flag from macro.
- WDLOAD  out  32  load value to macro.
- WDEN  out  1  macro enable; low for one cycle forces the macro to reload from WDLOAD.
- WDOVCLR  out  1  macro overflow clear.
- irq  out  1  warning interrupt, sticky.
- rst_req  out  1  system reset request.
- kick_err  out  1  one-cycle pulse on a bad key.
- state  out  3  current FSM state, for status readback.

## Operation
- States: IDLE=0, RELOAD=1, RUN=2, WARN=3, BITE=4.
- IDLE:
  - Outputs: WDEN=0, WDOVCLR=1.
  - Rising edge of cfg_en → RELOAD with sel=load; latch lock_q=cfg_lock.
- RELOAD (exactly 1 cycle):
  - Outputs: WDEN=0, WDOVCLR=1.
  - WDLOAD = (v==0) ? 1 : v, where v is cfg_load or cfg_grace per sel.
  - Next state is RUN (sel=load) or WARN (sel=grace).
- RUN:
  - Outputs: WDEN=1, WDOVCLR=0.
  - Valid kick → RELOAD(load).
  - WDOV=1 → RELOAD(grace) and set irq.
- WARN:
  - Outputs: WDEN=1.
  - Valid kick → RELOAD(load); irq remains set.
  - WDOV=1 → BITE.
- BITE:
  - Outputs: WDEN=0, rst_req=1.
  - Down-counter runs RST_CYCLES cycles, then → IDLE and clear lock_q.
  - A new rising edge of cfg_en is needed to re-arm.
- Kick detector (2 states, EXPECT1/EXPECT2):
  - In EXPECT1: kick_wr with KEY1 → EXPECT2.
  - In EXPECT2: kick_wr with KEY2 → valid kick, back to EXPECT1.
  - Any other kick_wr value → kick_err pulse, back to EXPECT1.
  - Idle cycles between the two writes are allowed.
  - Kicks in IDLE, RELOAD or BITE are discarded without error. The detector stays in EXPECT1 while in IDLE.
- Disarm: cfg_en=0 in RELOAD/RUN/WARN with lock_q=0 → IDLE. Ignored when lock_q=1.
- irq:
  - Set on the RUN-overflow event; cleared by irq_clr.
  - When set and clear occur in the same cycle, set wins.
  - irq is unaffected by disarm and by BITE.

## Timing
- Reset values:
  - state=IDLE, WDLOAD=0, WDEN=0, WDOVCLR=1.
  - irq=0, rst_req=0, kick_err=0, lock_q=0, kick detector=EXPECT1.
- All outputs are registered. The kick_err pulse appears the cycle after the offending kick_wr.
- Valid kick: the KEY2 strobe in cycle N → RELOAD in N+1 → WDEN=1 in N+2.
- Overflow blanking: WDOV is ignored during RELOAD and during the first cycle of RUN/WARN, because the macro's clear is registered.
- Priority (same cycle):
  - valid kick > WDOV;
  - disarm > kick > WDOV;
  - BITE is not interruptible except by PRESET.
- rst_req is high for exactly RST_CYCLES consecutive cycles.
- PRESET asserted mid-operation (including BITE) returns all outputs to their reset values immediately and asynchronously.
- Arm edge detection uses a registered cfg_en, which resets to 0. cfg_en held high through reset therefore arms once after reset release.

## Structure
- wdt32_pkg holds:
  - the state encoding constants;
  - KEY1/KEY2 defaults;
  - the RST_CYCLES default;
  - the sel encoding (LOAD/GRACE).
- Sub-module wdt32_kick_fsm: the key-sequence detector. It outputs kick_ok and kick_err, and takes the top-level enable (state ∈ {RUN, WARN}).
- The top level holds the main FSM, the BITE counter (width $clog2(RST_CYCLES+1)), the irq flop, lock_q and the cfg_en edge register.

## Test plan
- Arm and overflow: arm with cfg_load=100, cfg_grace=50; the model overflows → WARN, irq=1, WDLOAD=50. Second overflow → rst_req high 16 cycles, then state=IDLE.
- Keyed kick: in RUN, write 5A, wait 3 cycles, write A5 → state=RELOAD next cycle, WDEN=0 for one cycle, WDLOAD=100.
- Bad keys:
  - A5 alone → kick_err pulse, no reload.
  - 5A then 33 → kick_err, detector back in EXPECT1; a following 5A, A5 kicks.
- Simultaneous events:
  - KEY2 strobe and WDOV in the same RUN cycle → RELOAD(load), irq stays 0.
  - irq_clr and the overflow set in the same cycle → irq=1.
- Lock: arm with cfg_lock=1, drop cfg_en → stays in RUN. Arm with cfg_lock=0, drop cfg_en → IDLE, WDEN=0.
- Reset and zero load:
  - PRESET pulse during BITE → rst_req=0 and state=IDLE at once.
  - cfg_load=0 → WDLOAD=1.

Source files
------------

// File: rtl/wdt32_pkg.sv
// Shared encodings, default keys and helpers for the WDT32 watchdog sequencer.
package wdt32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RELOAD = 3'd1,
        ST_RUN    = 3'd2,
        ST_WARN   = 3'd3,
        ST_BITE   = 3'd4
    } wdt_state_e;

    typedef enum logic {
        SEL_LOAD  = 1'b0,
        SEL_GRACE = 1'b1
    } sel_e;

    typedef enum logic {
        KS_EXPECT1 = 1'b0,
        KS_EXPECT2 = 1'b1
    } kick_state_e;

    localparam logic [7:0]  KEY1_DEFAULT       = 8'h5A;
    localparam logic [7:0]  KEY2_DEFAULT       = 8'hA5;
    localparam int unsigned RST_CYCLES_DEFAULT = 16;

    // A zero load would let the macro overflow without any count; clamp to 1.
    function automatic logic [31:0] clamp_load(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'd0) begin
            r = 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/wdt32_kick_fsm.sv
// Two-write keyed kick detector; flags a valid kick combinationally and a bad key one cycle later.
module wdt32_kick_fsm
    import wdt32_pkg::*;
#(
    parameter logic [7:0] KEY1 = KEY1_DEFAULT,
    parameter logic [7:0] KEY2 = KEY2_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       kick_wr,
    input  logic [7:0] kick_key,
    output logic       kick_ok,
    output logic       kick_err
);

    kick_state_e ks;
    kick_state_e ks_nxt;
    logic        err_set;

    // Key sequence decode; outside RUN/WARN writes are dropped and the sequence restarts.
    always_comb begin
        ks_nxt  = ks;
        kick_ok = 1'b0;
        err_set = 1'b0;
        if (!en) begin
            ks_nxt = KS_EXPECT1;
        end else if (kick_wr) begin
            case (ks)
                KS_EXPECT1: begin
                    if (kick_key == KEY1) begin
                        ks_nxt = KS_EXPECT2;
                    end else begin
                        ks_nxt  = KS_EXPECT1;
                        err_set = 1'b1;
                    end
                end
                KS_EXPECT2: begin
                    ks_nxt = KS_EXPECT1;
                    if (kick_key == KEY2) begin
                        kick_ok = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    ks_nxt = KS_EXPECT1;
                end
            endcase
        end else begin
            ks_nxt = ks;
        end
    end

    // Detector state and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks       <= KS_EXPECT1;
            kick_err <= 1'b0;
        end else begin
            ks       <= ks_nxt;
            kick_err <= err_set;
        end
    end

endmodule

// File: rtl/wdt32_seq.sv
// Two-stage watchdog sequencer driving the WDT32 macro: keyed kicks, warning irq with grace, timed reset bite.
module wdt32_seq
    import wdt32_pkg::*;
#(
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEFAULT,
    parameter logic [7:0]  KEY1       = KEY1_DEFAULT,
    parameter logic [7:0]  KEY2       = KEY2_DEFAULT
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] cfg_load,
    input  logic [31:0] cfg_grace,
    input  logic        cfg_en,
    input  logic        cfg_lock,
    input  logic        kick_wr,
    input  logic [7:0]  kick_key,
    input  logic        irq_clr,
    input  logic        WDOV,
    output logic [31:0] WDLOAD,
    output logic        WDEN,
    output logic        WDOVCLR,
    output logic        irq,
    output logic        rst_req,
    output logic        kick_err,
    output logic [2:0]  state
);

    localparam int unsigned      CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    wdt_state_e       cur_state;
    wdt_state_e       nxt_state;
    sel_e             sel;
    sel_e             nxt_sel;
    logic             cfg_en_q;
    logic             lock_q;
    logic             blank_q;
    logic [CNT_W-1:0] bite_cnt;
    logic             kick_en;
    logic             kick_ok;
    logic             arm_rise;
    logic             disarm;
    logic             ov_evt;
    logic             irq_set;

    assign kick_en  = (cur_state == ST_RUN) || (cur_state == ST_WARN);
    assign arm_rise = cfg_en && !cfg_en_q;
    assign disarm   = ((cur_state == ST_RELOAD) || kick_en) && !cfg_en && !lock_q;
    // The macro's clear is registered, so its flag is stale until one cycle into RUN/WARN.
    assign ov_evt   = WDOV && !blank_q;
    assign irq_set  = (cur_state == ST_RUN) && !disarm && !kick_ok && ov_evt;
    assign state    = cur_state;

    wdt32_kick_fsm #(
        .KEY1 (KEY1),
        .KEY2 (KEY2)
    ) u_kick (
        .clk      (PCLK),
        .rst      (PRESET),
        .en       (kick_en),
        .kick_wr  (kick_wr),
        .kick_key (kick_key),
        .kick_ok  (kick_ok),
        .kick_err (kick_err)
    );

    // Main sequencer next-state: disarm beats kick, kick beats overflow.
    always_comb begin
        nxt_state = cur_state;
        nxt_sel   = sel;
        case (cur_state)
            ST_IDLE: begin
                if (arm_rise) begin
                    nxt_state = ST_RELOAD;
                    nxt_sel   = SEL_LOAD;
                end else begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_RELOAD: begin
                if (disarm) begin
                    nxt_state = ST_IDLE;
                end else if (sel == SEL_GRACE) begin
                    nxt_state = ST_WARN;
                end else begin
                    nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (disarm) begin
                    nxt_state = ST_IDLE;
                end else if (kick_ok) begin
                    nxt_state = ST_RELOAD;
                    nxt_sel   = SEL_LOAD;
                end else if (ov_evt) begin
                    nxt_state = ST_RELOAD;
                    nxt_sel   = SEL_GRACE;
                end else begin
                    nxt_state = ST_RUN;
                end
            end
            ST_WARN: begin
                if (disarm) begin
                    nxt_state = ST_IDLE;
                end else if (kick_ok) begin
                    nxt_state = ST_RELOAD;
                    nxt_sel   = SEL_LOAD;
                end else if (ov_evt) begin
                    nxt_state = ST_BITE;
                end else begin
                    nxt_state = ST_WARN;
                end
            end
            ST_BITE: begin
                if (bite_cnt <= CNT_LAST) begin
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_state = ST_BITE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_sel   = SEL_LOAD;
            end
        endcase
    end

    // State, control flops and registered macro/status outputs derived from the next state.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cur_state <= ST_IDLE;
            sel       <= SEL_LOAD;
            cfg_en_q  <= 1'b0;
            lock_q    <= 1'b0;
            blank_q   <= 1'b0;
            bite_cnt  <= '0;
            irq       <= 1'b0;
            WDLOAD    <= 32'd0;
            WDEN      <= 1'b0;
            WDOVCLR   <= 1'b1;
            rst_req   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            sel       <= nxt_sel;
            cfg_en_q  <= cfg_en;
            blank_q   <= (cur_state == ST_RELOAD);
            WDEN      <= (nxt_state == ST_RUN) || (nxt_state == ST_WARN);
            WDOVCLR   <= nxt_state inside {ST_IDLE, ST_RELOAD, ST_BITE};
            rst_req   <= (nxt_state == ST_BITE);

            if (nxt_state == ST_RELOAD) begin
                WDLOAD <= clamp_load((nxt_sel == SEL_GRACE) ? cfg_grace : cfg_load);
            end else begin
                WDLOAD <= WDLOAD;
            end

            if ((cur_state == ST_IDLE) && arm_rise) begin
                lock_q <= cfg_lock;
            end else if ((cur_state == ST_BITE) && (nxt_state == ST_IDLE)) begin
                lock_q <= 1'b0;
            end else begin
                lock_q <= lock_q;
            end

            if ((cur_state != ST_BITE) && (nxt_state == ST_BITE)) begin
                bite_cnt <= CNT_INIT;
            end else if (cur_state == ST_BITE) begin
                bite_cnt <= bite_cnt - CNT_LAST;
            end else begin
                bite_cnt <= bite_cnt;
            end

            // Overflow set wins over a same-cycle clear.
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end else begin
                irq <= irq;
            end
        end
    end

endmodule
